// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for the GCD requester and related schedulers.
// Holds the 2-bit requester state encoding and the default WIDTH/TIMEOUT.
package gcd_pkg;

  localparam int GCD_WIDTH_DEFAULT   = 8;
  localparam int GCD_TIMEOUT_DEFAULT = 1024;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_LOAD = 2'd1;
  localparam logic [1:0] ENC_RUN  = 2'd2;
  localparam logic [1:0] ENC_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ENC_IDLE,
    LOAD = ENC_LOAD,
    RUN  = ENC_RUN,
    DONE = ENC_DONE
  } gcd_state_e;

endpackage

// File: rtl/gcd_watchdog.sv
// gcd_watchdog: run-length watchdog for one GCD unit.
// Down-counter loaded with TIMEOUT-1 while clear is high; it decrements once
// per enabled cycle and saturates at zero (terminal count), never wrapping.
// expired is high while the terminal count is reached, i.e. in the TIMEOUT-th
// enabled cycle after the last clear.
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous, active-high reset (reloads the counter)
//   clear   - reload the counter to TIMEOUT-1
//   enable  - count this cycle
//   expired - terminal count reached
module gcd_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC_LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] remaining;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      remaining <= TC_LOAD;
    end else if (enable && (remaining != '0)) begin
      remaining <= remaining - CW'(1);
    end
  end

  assign expired = (remaining == '0);

endmodule

// File: rtl/gcd_requester.sv
// gcd_requester: initiator side of the GCD unit's start/finished handshake.
// Accepts an operand pair, drives the GCD controller through LOAD/RUN, captures
// the result on the first finished and returns operands plus result. Zero
// operands are resolved locally (the subtractive unit never terminates on
// them) and every run is bounded by a watchdog.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b - operand input stream
//   gcd_start, gcd_op_a/b       - start and operands to the GCD unit
//   gcd_finished, gcd_result    - completion and result from the GCD unit
//   out_valid/out_ready         - result output stream
//   out_a/out_b/out_gcd         - echoed operands and result (0 on error)
//   out_error                   - run aborted by watchdog
//   busy                        - not in IDLE
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// LOAD  | operands presented, start low so the unit loads them
// RUN   | start high, waiting for finished or watchdog expiry
// DONE  | result presented on out_*, waiting for out_ready
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH_DEFAULT,
  parameter int TIMEOUT = GCD_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_op_a,
  output logic [WIDTH-1:0] gcd_op_b,
  input  logic             gcd_finished,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_error,
  output logic             busy
);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic             err_q, err_d;
  logic             start_q, valid_q, ready_q, busy_q;
  logic             wd_expired;

  gcd_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != RUN),
    .enable (state_q == RUN),
    .expired(wd_expired)
  );

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    gcd_d   = gcd_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && ready_q) begin
          op_a_d = in_a;
          op_b_d = in_b;
          // gcd(x,0)=x and gcd(0,0)=0, both covered by the OR.
          if ((in_a == '0) || (in_b == '0)) begin
            gcd_d   = in_a | in_b;
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        // finished takes priority over a same-cycle watchdog expiry
        if (gcd_finished) begin
          gcd_d   = gcd_result;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (wd_expired) begin
          gcd_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered decodes of the next state so they line
  // up with state_q; finished arriving outside RUN is never looked at.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      gcd_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      gcd_q   <= gcd_d;
      err_q   <= err_d;
      start_q <= (state_d == RUN);
      valid_q <= (state_d == DONE);
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign in_ready  = ready_q;
  assign gcd_start = start_q;
  assign gcd_op_a  = op_a_q;
  assign gcd_op_b  = op_b_q;
  assign out_valid = valid_q;
  assign out_a     = op_a_q;
  assign out_b     = op_b_q;
  assign out_gcd   = gcd_q;
  assign out_error = err_q;
  assign busy      = busy_q;

endmodule
